// File: rtl/irrigation_pkg.sv
// Shared types and default timing for the irrigation scheduler.
// The MANUAL_OVERRIDE_EN build option is handled in irrigation_scheduler.sv.
package irrigation_pkg;

  localparam int TW_DEF           = 10;
  localparam int SPRINKLE_MAX_DEF = 300;
  localparam int DRIP_MAX_DEF     = 600;
  localparam int REST_MIN_DEF     = 60;
  localparam int FILL_TIMEOUT_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_REST     = 3'd3,
    ST_FAULT    = 3'd4
  } irr_state_e;

  function automatic logic is_run(irr_state_e s);
    return (s == ST_SPRINKLE) || (s == ST_DRIP);
  endfunction

endpackage

// File: rtl/tank_fill_ctrl.sv
// Tank fill valve: opens below medium level, closes at high level, and
// raises fill_timeout after FILL_TIMEOUT_S ticks of continuous opening.
module tank_fill_ctrl
  import irrigation_pkg::*;
#(
  parameter int TW             = TW_DEF,
  parameter int FILL_TIMEOUT_S = FILL_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1hz,
  input  logic h_lvl,
  input  logic m_lvl,
  input  logic force_off,
  output logic ve,
  output logic fill_timeout
);

  localparam logic [TW-1:0] FILL_LOAD = TW'(FILL_TIMEOUT_S);

  logic [TW-1:0] fill_rem;
  logic          ve_d;

  always_comb begin
    ve_d = ve;
    if (force_off || h_lvl) begin
      ve_d = 1'b0;
    end else if (!m_lvl) begin
      ve_d = 1'b1;
    end
  end

  // Down-counter reloads whenever the valve is closed; terminal count is the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ve       <= 1'b0;
      fill_rem <= FILL_LOAD;
    end else begin
      ve <= ve_d;
      if (!ve) begin
        fill_rem <= FILL_LOAD;
      end else if (tick_1hz && (fill_rem != '0)) begin
        fill_rem <= fill_rem - 1'b1;
      end
    end
  end

  assign fill_timeout = ve && (fill_rem == '0);

endmodule

// File: rtl/irrigation_scheduler.sv
// Timed sprinkler/drip sequencer with rest interval, tank fill supervision and latched fault.
// Define MANUAL_OVERRIDE_EN to add man_req/man_sel for operator-started runs.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int SPRINKLE_MAX_S = SPRINKLE_MAX_DEF,
  parameter int DRIP_MAX_S     = DRIP_MAX_DEF,
  parameter int REST_MIN_S     = REST_MIN_DEF,
  parameter int FILL_TIMEOUT_S = FILL_TIMEOUT_DEF,
  parameter int TW             = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic          H,
  input  logic          M,
  input  logic          L,
  input  logic          Ua,
  input  logic          Us,
  input  logic          T,
`ifdef MANUAL_OVERRIDE_EN
  input  logic          man_req,
  input  logic          man_sel,
`endif
  output logic          Ve,
  output logic          Vs,
  output logic          Bs,
  output logic          Erro,
  output logic          Alarme,
  output logic [2:0]    state,
  output logic [TW-1:0] elapsed,
  output logic          cycle_done
);

  // state    | meaning
  // IDLE     | waiting for soil-dry demand with water available
  // SPRINKLE | sprinkler run, Vs on, bounded by SPRINKLE_MAX_S
  // DRIP     | drip run, Bs on, chosen when hot or humid
  // REST     | mandatory off time after every run
  // FAULT    | latched level/fill fault, absorbing until reset

  localparam logic [TW-1:0] SPRINKLE_LAST = TW'(SPRINKLE_MAX_S - 1);
  localparam logic [TW-1:0] DRIP_LAST     = TW'(DRIP_MAX_S - 1);
  localparam logic [TW-1:0] REST_LAST     = TW'(REST_MIN_S - 1);

  logic [5:0]    sync_s1, sync_s2;
  logic          h_s, m_s, l_s, ua_s, us_s, t_s;
  irr_state_e    state_q, state_d;
  logic [TW-1:0] elapsed_q, elapsed_d;
  logic [TW-1:0] run_last;
  logic          fault_cond, fill_timeout, timed, demand_lost;
  logic          man_start, man_pick, man_run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= {H, M, L, Ua, Us, T};
      sync_s2 <= sync_s1;
    end
  end

  assign {h_s, m_s, l_s, ua_s, us_s, t_s} = sync_s2;

`ifdef MANUAL_OVERRIDE_EN
  logic [2:0] man_req_sr;
  logic [1:0] man_sel_sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      man_req_sr <= '0;
      man_sel_sr <= '0;
    end else begin
      man_req_sr <= {man_req_sr[1:0], man_req};
      man_sel_sr <= {man_sel_sr[0], man_sel};
    end
  end

  assign man_start = man_req_sr[1] & ~man_req_sr[2];
  assign man_pick  = man_sel_sr[1];

  // A manual run ignores soil moisture for its whole duration, not just at start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      man_run_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      man_run_q <= man_start && l_s && (state_d != ST_FAULT);
    end else begin
      man_run_q <= man_run_q && (state_d == state_q);
    end
  end
`else
  assign man_start = 1'b0;
  assign man_pick  = 1'b0;
  assign man_run_q = 1'b0;
`endif

  assign fault_cond  = (h_s & ~m_s) | (m_s & ~l_s) | fill_timeout;
  assign run_last    = (state_q == ST_DRIP) ? DRIP_LAST : SPRINKLE_LAST;
  assign demand_lost = !us_s && !man_run_q;
  assign timed       = is_run(state_q) || (state_q == ST_REST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (man_start && l_s) begin
          state_d = man_pick ? ST_DRIP : ST_SPRINKLE;
        end else if (us_s && l_s) begin
          state_d = (t_s || ua_s) ? ST_DRIP : ST_SPRINKLE;
        end
      end
      ST_SPRINKLE, ST_DRIP: begin
        if (demand_lost || !l_s || (tick_1hz && (elapsed_q == run_last))) begin
          state_d = ST_REST;
        end
      end
      ST_REST: begin
        if (tick_1hz && (elapsed_q == REST_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_FAULT;
    endcase
    if (fault_cond) begin
      state_d = ST_FAULT;
    end
  end

  // A state change in the same clk as a tick leaves elapsed at zero.
  always_comb begin
    elapsed_d = elapsed_q;
    if (state_d != state_q) begin
      elapsed_d = '0;
    end else if (tick_1hz && timed && (elapsed_q != {TW{1'b1}})) begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elapsed_q  <= '0;
      Vs         <= 1'b0;
      Bs         <= 1'b0;
      Erro       <= 1'b0;
      Alarme     <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      elapsed_q  <= elapsed_d;
      Vs         <= (state_d == ST_SPRINKLE);
      Bs         <= (state_d == ST_DRIP);
      Erro       <= (state_d == ST_FAULT);
      Alarme     <= !l_s && (state_d != ST_FAULT);
      cycle_done <= is_run(state_q) && (state_d == ST_REST);
    end
  end

  tank_fill_ctrl #(
    .TW             (TW),
    .FILL_TIMEOUT_S (FILL_TIMEOUT_S)
  ) u_fill (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .h_lvl        (h_s),
    .m_lvl        (m_s),
    .force_off    (state_d == ST_FAULT),
    .ve           (Ve),
    .fill_timeout (fill_timeout)
  );

  assign state   = state_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios plus random sensor
// episodes, all checked cycle by cycle against a behavioural model.
module tb_irrigation_scheduler;

  localparam int SPR_MAX = 300;
  localparam int DRP_MAX = 600;
  localparam int RST_MIN = 60;
  localparam int FILL_TO = 120;
  localparam int EL_SAT  = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       H = 1'b0, M = 1'b0, L = 1'b0, Ua = 1'b0, Us = 1'b0, T = 1'b0;
  logic       Ve, Vs, Bs, Erro, Alarme, cycle_done;
  logic [2:0] state;
  logic [9:0] elapsed;
`ifdef MANUAL_OVERRIDE_EN
  logic       man_req = 1'b0, man_sel = 1'b0;
`endif

  irrigation_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .H          (H),
    .M          (M),
    .L          (L),
    .Ua         (Ua),
    .Us         (Us),
    .T          (T),
`ifdef MANUAL_OVERRIDE_EN
    .man_req    (man_req),
    .man_sel    (man_sel),
`endif
    .Ve         (Ve),
    .Vs         (Vs),
    .Bs         (Bs),
    .Erro       (Erro),
    .Alarme     (Alarme),
    .state      (state),
    .elapsed    (elapsed),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Behavioural model: plant mode, seconds in mode, valve and open-time in ticks.
  int       m_state, m_el, m_fill;
  bit       m_ve, m_cd, m_al;
  bit [5:0] hist1, hist2;
  int       tick_gap, spr_ticks, rest_ticks, n_ticks, cd_seen;

  task automatic model_reset();
    m_state = 0; m_el = 0; m_fill = 0;
    m_ve = 0; m_cd = 0; m_al = 0;
    hist1 = '0; hist2 = '0;
  endtask

  task automatic model_step(input bit [5:0] inp, input bit tk);
    bit h, m, l, ua, us, t, timeout;
    int prev, nxt, limit;
    {h, m, l, ua, us, t} = hist2;
    hist2 = hist1;
    hist1 = inp;
    prev = m_state;
    nxt = prev;
    timeout = m_ve && (m_fill == FILL_TO);
    if (prev == 4 || (h && !m) || (m && !l) || timeout) begin
      nxt = 4;
    end else if (prev == 0) begin
      if (us && l) nxt = (t || ua) ? 2 : 1;
    end else if (prev == 1 || prev == 2) begin
      limit = (prev == 1) ? SPR_MAX : DRP_MAX;
      if (!us || !l || (tk && m_el + 1 == limit)) nxt = 3;
    end else if (prev == 3) begin
      if (tk && m_el + 1 == RST_MIN) nxt = 0;
    end
    if (!m_ve) m_fill = 0;
    else if (tk && m_fill < FILL_TO) m_fill = m_fill + 1;
    if (nxt == 4 || h) m_ve = 0;
    else if (!m) m_ve = 1;
    if (nxt != prev) m_el = 0;
    else if (tk && prev >= 1 && prev <= 3 && m_el < EL_SAT) m_el = m_el + 1;
    m_cd = (prev == 1 || prev == 2) && nxt == 3;
    m_al = !l && nxt != 4;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("elapsed", 32'(elapsed), 32'(m_el));
    check("valves", 32'({Ve, Vs, Bs}), 32'({m_ve, m_state == 1, m_state == 2}));
    check("flags", 32'({Erro, Alarme, cycle_done}), 32'({m_state == 4, m_al, m_cd}));
  endtask

  // One clock: drive at negedge, model the coming edge, compare after it.
  task automatic step(input bit [5:0] inp);
    bit tk;
    tk = (tick_gap == 0);
    tick_gap = tk ? int'($urandom_range(1, 2)) : tick_gap - 1;
    {H, M, L, Ua, Us, T} = inp;
    tick_1hz = tk;
    if (tk) begin
      n_ticks++;
      if (state == 3'd1) spr_ticks++;
      if (state == 3'd3) rest_ticks++;
    end
    model_step(inp, tk);
    @(posedge clk);
    #1;
    compare_all();
    if (cycle_done) cd_seen++;
    @(negedge clk);
  endtask

  task automatic run_until(input bit [5:0] inp, input int st, input int el, input int budget,
                           input string tag);
    int n;
    n = 0;
    while (!(m_state == st && (el < 0 || m_el == el)) && n < budget) begin
      step(inp);
      n++;
    end
    check(tag, 32'(m_state == st && (el < 0 || m_el == el)), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {H, M, L, Ua, Us, T} = '0;
    tick_1hz = 1'b0;
    model_reset();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({Ve, Vs, Bs, Erro, Alarme, cycle_done}), 32'd0);
    check("rst_elapsed", 32'(elapsed), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick_gap = 1;
  endtask

  function automatic bit [2:0] lvl_bits(input int n);
    case (n)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b011;
      3: return 3'b111;
      4: return 3'b101;
      5: return 3'b010;
      6: return 3'b100;
      default: return 3'b110;
    endcase
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0] cur;
    int start_ticks;
    // {H,M,L,Ua,Us,T}
    @(negedge clk);

    // Sprinkler run to its limit, then rest back to idle.
    do_reset();
    cur = {3'b111, 1'b0, 1'b1, 1'b0};
    repeat (3) step(cur);
    check("tp1_state", 32'(state), 32'd1);
    check("tp1_vs", 32'(Vs), 32'd1);
    spr_ticks = 0; cd_seen = 0;
    run_until(cur, 3, -1, 2000, "tp1_reach_rest");
    check("tp1_run_ticks", 32'(spr_ticks), 32'(SPR_MAX));
    check("tp1_cd_count", 32'(cd_seen), 32'd1);
    check("tp1_vs_off", 32'(Vs), 32'd0);
    rest_ticks = 0;
    run_until(cur, 0, -1, 400, "tp1_reach_idle");
    check("tp1_rest_ticks", 32'(rest_ticks), 32'(RST_MIN));

    // Hot drip run, soil turns wet at elapsed 17.
    do_reset();
    cur = {3'b111, 1'b0, 1'b1, 1'b1};
    run_until(cur, 2, 17, 200, "tp2_reach_17");
    check("tp2_bs", 32'(Bs), 32'd1);
    cur = {3'b111, 1'b0, 1'b0, 1'b1};
    repeat (3) step(cur);
    check("tp2_rest", 32'(state), 32'd3);
    check("tp2_elapsed0", 32'(elapsed), 32'd0);

    // Fill opens below medium, closes at high, no fault.
    do_reset();
    cur = {3'b001, 1'b0, 1'b0, 1'b0};
    repeat (3) step(cur);
    check("tp3_ve_on", 32'(Ve), 32'd1);
    start_ticks = n_ticks;
    while (n_ticks - start_ticks < 40) step(cur);
    cur = {3'b011, 1'b0, 1'b0, 1'b0};
    repeat (3) step(cur);
    cur = {3'b111, 1'b0, 1'b0, 1'b0};
    repeat (3) step(cur);
    check("tp3_ve_off", 32'(Ve), 32'd0);
    check("tp3_no_fault", 32'(Erro), 32'd0);

    // Fill never reaches high: timeout fault, absorbing.
    do_reset();
    cur = {3'b001, 1'b0, 1'b0, 1'b0};
    run_until(cur, 4, -1, 1000, "tp4_reach_fault");
    check("tp4_erro", 32'(Erro), 32'd1);
    check("tp4_ve", 32'(Ve), 32'd0);
    cur = {3'b111, 1'b0, 1'b1, 1'b0};
    repeat (50) step(cur);
    check("tp4_absorbing", 32'(state), 32'd4);

    // Inconsistent levels during a sprinkler run.
    do_reset();
    cur = {3'b111, 1'b0, 1'b1, 1'b0};
    run_until(cur, 1, 5, 100, "tp5_in_sprinkle");
    cur = {3'b101, 1'b0, 1'b1, 1'b0};
    repeat (3) step(cur);
    check("tp5_fault", 32'(state), 32'd4);
    check("tp5_vs_alarm", 32'({Vs, Alarme}), 32'd0);

    // Asynchronous reset in the middle of a drip run.
    do_reset();
    cur = {3'b111, 1'b1, 1'b1, 1'b0};
    run_until(cur, 2, 250, 1500, "tp6_reach_250");
    #2 reset = 1'b0;
    #1;
    check("tp6_async_outs", 32'({Ve, Vs, Bs, Erro, Alarme, cycle_done}), 32'd0);
    check("tp6_async_state", 32'(state), 32'd0);
    check("tp6_async_elapsed", 32'(elapsed), 32'd0);
    @(negedge clk);
    do_reset();
    step(cur);
    check("tp6_after_state", 32'(state), 32'd0);

    // Random sensor episodes.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int sg = 0; sg < 8 && m_state != 4; sg++) begin
        int lv;
        lv = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
        cur = {lvl_bits(lv), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 1))};
        repeat ($urandom_range(20, 700)) step(cur);
      end
      repeat (20) step(cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
